// File: rtl/rfile_wb.sv
// rfile_wb: in-order writeback queue that feeds the write ports of rfile.
// Each cycle it issues the longest run of head entries whose target registers are distinct.
module rfile_wb #(
    parameter int XLEN           = 64,
    parameter int XWDT           = 6,
    parameter int XN             = 64,
    parameter int PARALLELACCESS = 3,
    parameter int DEPTH          = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [PARALLELACCESS-1:0]                   in_valid,
    output logic                                        in_ready,
    input  logic [PARALLELACCESS-1:0][XWDT-1:0]         in_reg,
    input  logic [PARALLELACCESS-1:0][XLEN-1:0]         in_data,
    input  logic [PARALLELACCESS-1:0][1:0]              in_size,
    input  logic [PARALLELACCESS-1:0][2:0]              in_pos,
    output logic [PARALLELACCESS-1:0][XWDT-1:0]         rwrites,
    output logic [PARALLELACCESS-1:0][XLEN-1:0]         rins,
    output logic [PARALLELACCESS-1:0][1:0]              rwsizes,
    output logic [PARALLELACCESS-1:0][2:0]              rwposs,
    output logic                                        we,
    output logic [XN-1:0]                               pending,
    output logic [$clog2(DEPTH+1)-1:0]                  count
);
    localparam int P  = PARALLELACCESS;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Slot index only means something within the access size, so higher bits are dropped.
    function automatic logic [2:0] mask_pos(input logic [1:0] size, input logic [2:0] pos);
        case (size)
            2'b00:   mask_pos = pos;
            2'b01:   mask_pos = pos & 3'b011;
            2'b10:   mask_pos = pos & 3'b001;
            default: mask_pos = 3'b000;
        endcase
    endfunction

    logic [XWDT-1:0]      reg_mem  [DEPTH];
    logic [XLEN-1:0]      data_mem [DEPTH];
    logic [1:0]           size_mem [DEPTH];
    logic [2:0]           pos_mem  [DEPTH];
    logic [AW-1:0]        rd_ptr_r;
    logic [AW-1:0]        wr_ptr_r;
    logic [P-1:0][AW-1:0] head_idx_s;
    logic [P-1:0][AW-1:0] slot_s;
    logic [CW-1:0]        k_s;
    logic [CW-1:0]        acc_s;
    logic                 fire_s;

    assign in_ready = (count <= CW'(DEPTH - P));

    // Group selection: stop at the first head entry that repeats an earlier register.
    always_comb begin
        logic stop;
        logic dup;
        k_s  = '0;
        stop = 1'b0;
        dup  = 1'b0;
        for (int i = 0; i < P; i++) begin
            head_idx_s[i] = rd_ptr_r + AW'(i);
        end
        for (int i = 0; i < P; i++) begin
            dup = 1'b0;
            for (int j = 0; j < i; j++) begin
                dup = dup | (reg_mem[head_idx_s[j]] == reg_mem[head_idx_s[i]]);
            end
            if (!stop && !dup && (CW'(i) < count)) begin
                k_s = CW'(i + 1);
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Enqueue compaction: each valid lane takes the next free slot in lane order.
    always_comb begin
        logic [CW-1:0] run;
        run = '0;
        for (int i = 0; i < P; i++) begin
            slot_s[i] = wr_ptr_r + AW'(run);
            run       = run + CW'(in_valid[i]);
        end
        fire_s = in_ready & (|in_valid);
        acc_s  = fire_s ? run : '0;
    end

    // FIFO storage; occupancy lives in the pointers, so contents need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < P; i++) begin
            if (fire_s && in_valid[i]) begin
                reg_mem[slot_s[i]]  <= in_reg[i];
                data_mem[slot_s[i]] <= in_data[i];
                size_mem[slot_s[i]] <= in_size[i];
                pos_mem[slot_s[i]]  <= mask_pos(in_size[i], in_pos[i]);
            end
        end
    end

    // Pointers, occupancy and the registered write group presented to rfile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count    <= '0;
            we       <= 1'b0;
            rwrites  <= '0;
            rins     <= '0;
            rwsizes  <= '0;
            rwposs   <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_r + AW'(k_s);
            wr_ptr_r <= wr_ptr_r + AW'(acc_s);
            count    <= count + acc_s - k_s;
            we       <= (k_s != '0);
            for (int i = 0; i < P; i++) begin
                if (k_s == '0) begin
                    rwrites[i] <= '0;
                    rins[i]    <= '0;
                    rwsizes[i] <= '0;
                    rwposs[i]  <= '0;
                end else if (CW'(i) < k_s) begin
                    rwrites[i] <= reg_mem[head_idx_s[i]];
                    rins[i]    <= data_mem[head_idx_s[i]];
                    rwsizes[i] <= size_mem[head_idx_s[i]];
                    rwposs[i]  <= pos_mem[head_idx_s[i]];
                end else begin
                    // Unused lanes repeat lane 0 so the shared we stays harmless.
                    rwrites[i] <= reg_mem[head_idx_s[0]];
                    rins[i]    <= data_mem[head_idx_s[0]];
                    rwsizes[i] <= size_mem[head_idx_s[0]];
                    rwposs[i]  <= pos_mem[head_idx_s[0]];
                end
            end
        end
    end

    // Hazard mask: queued entries plus the group currently on the rfile ports.
    always_comb begin
        pending = '0;
        for (int j = 0; j < DEPTH; j++) begin
            pending[reg_mem[rd_ptr_r + AW'(j)]] = pending[reg_mem[rd_ptr_r + AW'(j)]] | (CW'(j) < count);
        end
        for (int i = 0; i < P; i++) begin
            pending[rwrites[i]] = pending[rwrites[i]] | we;
        end
    end

endmodule
